demux2_stream: RTL and testbench
================================

// Module: demux2_stream
// PURPOSE
//   1:2 stream demultiplexer with valid/ready handshakes; the steering counterpart of mux2.
//   Accepts one N-wide word per cycle and routes it to output channel 0 or 1 using a
//   per-word select bit. Each channel buffers words in its own 2-entry FIFO.
//   Sits between a single producer (e.g. multiplier result path) and two consumers.
// PARAMETERS
//   WIDTH   8   data width of input and both output channels
//   CNT_W   8   width of per-channel accepted-word counters (wrap modulo 2^CNT_W)
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous reset, active high
//   in_valid    in   1       producer has a word on in_data
//   in_sel      in   1       destination channel for in_data: 0 -> out0, 1 -> out1
//   in_data     in   WIDTH   input word
//   in_ready    out  1       word accepted at this edge when in_valid && in_ready
//   out0_valid  out  1       channel 0 FIFO non-empty
//   out0_ready  in   1       consumer 0 takes head word when out0_valid && out0_ready
//   out0_data   out  WIDTH   channel 0 head word
//   out1_valid  out  1       channel 1 FIFO non-empty
//   out1_ready  in   1       consumer 1 takes head word when out1_valid && out1_ready
//   out1_data   out  WIDTH   channel 1 head word
//   cnt0        out  CNT_W   words accepted into channel 0 since reset
//   cnt1        out  CNT_W   words accepted into channel 1 since reset
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high. Reset dominates all other
//     inputs on that edge.
//   - Reset values: both FIFO occupancies = 0, both FIFO storage entries = 0,
//     out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0.
//     in_ready = 1 in the cycle after reset.
//   - Per-channel FIFO: 2 entries with occupancy occ_k in {0,1,2}.
//     outK_valid = (occ_k != 0). outK_data = the head entry.
//     When occ_k == 0, outK_data holds the last-popped or reset value and has no meaning.
//   - in_ready = (occ[in_sel] != 2). This is combinational from in_sel and the occupancy
//     registers only. It does not depend on outK_ready: there is no same-cycle bypass
//     when the channel is full.
//   - Push: in_valid && in_ready at an edge writes in_data to the tail of FIFO in_sel.
//     occ increments and cnt[in_sel] increments by 1, wrapping 2^CNT_W-1 -> 0.
//   - Pop: outK_valid && outK_ready at an edge removes the head; occ_k decrements.
//   - Push and pop on the same channel in the same edge: occ_k unchanged and order is
//     preserved (FIFO order strictly maintained).
//     - Case occ_k = 1: the new word becomes head next cycle.
//   - Pushes to one channel and pops from the other are independent and concurrent.
//   - Latency: a pushed word is visible on outK_data/outK_valid the cycle after acceptance.
//     There is no combinational path from in_data to outK_data.
//   - Throughput: 1 word/cycle per channel when the consumer holds ready high (occ stays <= 1).
//   - in_valid low: no push, no counter change, regardless of in_sel or in_data.
//   - Full channel with in_valid high: the word is held by the producer (in_ready low).
//     - The other channel is unaffected.
//     - If in_sel changes to a non-full channel, in_ready rises in the same cycle.
//   - outK_ready while outK_valid = 0: no effect.
//   - Reset mid-stream: buffered words are discarded, counters cleared, and no pop or push
//     is recorded on the reset edge.
//   - Protocol rule for producers: once in_valid is high, in_data and in_sel stay stable
//     until accepted. Consumers may toggle ready freely.
// TESTING  (WIDTH=8, CNT_W=8)
//   1. Reset, then hold out*_ready=1; push 8'hA5 sel0 and 8'h3C sel1 on consecutive cycles
//      -> out0 shows A5 one cycle after its push, out1 shows 3C one cycle after its push;
//      cnt0=1, cnt1=1.
//   2. out0_ready=0; push 11,22,33 to sel0 -> first two accepted (occ=2), in_ready=0 on the
//      third; raise out0_ready -> pops 11 then 22, then 33 is accepted; order 11,22,33.
//   3. Channel 0 full, in_sel=1 with in_valid -> in_ready=1 and the word enters out1 while
//      out0 is unchanged.
//   4. occ0=1 (head 44), push 55 sel0 with out0_ready=1 on the same edge -> next cycle occ0
//      stays 1 and out0_data=55; cnt0 increments.
//   5. 256 accepted pushes to sel1 -> cnt1 wraps to 0; cnt0 unchanged.
//   6. Assert reset with occ0=2, occ1=1 -> next cycle all valids 0, data 0, cnt 0,
//      in_ready=1; a push on the reset edge is not counted.

Source files
------------

// File: rtl/demux2_stream.sv
// 1:2 valid/ready stream demultiplexer steering each word by in_sel.
// Each output channel has a 2-entry FIFO and a wrapping accepted-word counter.
module demux2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic [1:0]       occ  [2];
    logic [WIDTH-1:0] head [2];
    logic [WIDTH-1:0] tail [2];
    logic [CNT_W-1:0] cnt  [2];
    logic [1:0]       push;
    logic [1:0]       pop;

    // Ready looks only at the selected channel's occupancy, never at consumer ready.
    always_comb begin
        in_ready = in_sel ? (occ[1] != 2'd2) : (occ[0] != 2'd2);
        push     = 2'b00;
        pop      = 2'b00;
        push[0]  = in_valid && in_ready && !in_sel;
        push[1]  = in_valid && in_ready && in_sel;
        pop[0]   = (occ[0] != 2'd0) && out0_ready;
        pop[1]   = (occ[1] != 2'd0) && out1_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                occ[k]  <= 2'd0;
                head[k] <= '0;
                tail[k] <= '0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                unique case ({push[k], pop[k]})
                    2'b10: begin
                        if (occ[k] == 2'd0) head[k] <= in_data;
                        else                tail[k] <= in_data;
                        occ[k] <= occ[k] + 2'd1;
                    end
                    2'b01: begin
                        // With one entry left the head keeps the popped word.
                        if (occ[k] == 2'd2) head[k] <= tail[k];
                        occ[k] <= occ[k] - 2'd1;
                    end
                    2'b11: begin
                        if (occ[k] == 2'd2) begin
                            head[k] <= tail[k];
                            tail[k] <= in_data;
                        end else begin
                            head[k] <= in_data;
                        end
                    end
                    default: ;
                endcase
                if (push[k]) cnt[k] <= cnt[k] + CNT_W'(1);
            end
        end
    end

    assign out0_valid = (occ[0] != 2'd0);
    assign out1_valid = (occ[1] != 2'd0);
    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: directed pushes queue expected words,
// a monitor pops and compares on every output handshake.
module tb_demux2_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_sel;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] m0;
    logic [7:0] m1;
    int n_checks = 0;
    int n_fail   = 0;

    demux2_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_sel(in_sel),
        .in_data(in_data),
        .in_ready(in_ready),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out0_data(out0_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data(out1_data),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a word at the current negedge; expected acceptance is hand-specified.
    task automatic send(input logic sel, input logic [7:0] d, input logic exp_rdy);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        #1;
        check("in_ready", in_ready, exp_rdy);
        if (exp_rdy) begin
            if (sel) begin q1.push_back(d); m1++; end
            else     begin q0.push_back(d); m0++; end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        m0 = '0;
        m1 = '0;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        #2;
        if (!reset && out0_valid && out0_ready) begin
            if (q0.size() == 0) check("out0_unexpected", 1, 0);
            else check("out0_data", out0_data, q0.pop_front());
        end
        if (!reset && out1_valid && out1_ready) begin
            if (q1.size() == 0) check("out1_unexpected", 1, 0);
            else check("out1_data", out1_data, q1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 8'h00;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        m0 = '0;
        m1 = '0;
        @(negedge clk);
        do_reset();
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data", out0_data, 0);
        check("rst_out1_data", out1_data, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_in_ready", in_ready, 1);

        // basic steering and latency
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        send(0, 8'hA5, 1);
        check("t1_out0_valid", out0_valid, 1);
        check("t1_out0_data", out0_data, 8'hA5);
        send(1, 8'h3C, 1);
        check("t1_out1_valid", out1_valid, 1);
        check("t1_out1_data", out1_data, 8'h3C);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_cnt0", cnt0, 1);
        check("t1_cnt1", cnt1, 1);
        check("t1_out0_drained", out0_valid, 0);

        // fill channel 0, back-pressure, then drain in order
        out0_ready = 1'b0;
        send(0, 8'h11, 1);
        send(0, 8'h22, 1);
        send(0, 8'h33, 0);
        out0_ready = 1'b1;
        #1;
        check("t2_no_bypass", in_ready, 0);
        @(negedge clk);
        send(0, 8'h33, 1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t2_cnt0", cnt0, 4);

        // full channel 0 does not block channel 1
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(0, 8'h66, 1);
        send(0, 8'h77, 1);
        send(0, 8'h88, 0);
        send(1, 8'h99, 1);
        in_valid = 1'b0;
        check("t3_out0_valid", out0_valid, 1);
        check("t3_out0_data", out0_data, 8'h66);
        check("t3_out1_valid", out1_valid, 1);
        check("t3_out1_data", out1_data, 8'h99);
        check("t3_cnt1", cnt1, 2);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (3) @(negedge clk);

        // simultaneous push and pop with one entry buffered
        out0_ready = 1'b0;
        send(0, 8'h44, 1);
        out0_ready = 1'b1;
        send(0, 8'h55, 1);
        in_valid = 1'b0;
        #1;
        check("t4_out0_valid", out0_valid, 1);
        check("t4_out0_data", out0_data, 8'h55);
        check("t4_cnt0", cnt0, 8);
        check("t4_cnt0_model", cnt0, m0);
        @(negedge clk);
        #1;
        check("t4_occ_one", out0_valid, 0);
        @(negedge clk);

        // counter wrap on channel 1
        do_reset();
        for (int i = 0; i < 255; i++) send(1, 8'(i), 1);
        in_valid = 1'b0;
        check("t5_cnt1_255", cnt1, 8'hFF);
        send(1, 8'hEE, 1);
        in_valid = 1'b0;
        check("t5_cnt1_wrap", cnt1, 0);
        check("t5_cnt1_model", cnt1, m1);
        check("t5_cnt0", cnt0, 0);
        @(negedge clk);
        @(negedge clk);

        // reset mid-stream with a push and pops offered on the reset edge
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(0, 8'hA1, 1);
        send(0, 8'hA2, 1);
        send(1, 8'hB1, 1);
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 8'hC3;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        do_reset();
        check("t6_out0_valid", out0_valid, 0);
        check("t6_out1_valid", out1_valid, 0);
        check("t6_out0_data", out0_data, 0);
        check("t6_out1_data", out1_data, 0);
        check("t6_cnt0", cnt0, 0);
        check("t6_cnt1", cnt1, 0);
        check("t6_in_ready", in_ready, 1);
        @(negedge clk);
        check("t6_idle_out1", out1_valid, 0);

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
